// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - four-stage pipelined IEEE-754 adder/subtractor with global-stall flow control
// FP_ADDSUB_SUBNORMAL_EN selects gradual underflow; undefined flushes subnormals to zero.
module fp_addsub_pipe #(
   parameter int EXPO_WIDTH = 8,
   parameter int MENT_WIDTH = 23,
   parameter int DATA_WIDTH = 1 + EXPO_WIDTH + MENT_WIDTH,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  in_valid_in,
   output logic                  in_ready_out,
   input  logic [DATA_WIDTH-1:0] floating1_in,
   input  logic [DATA_WIDTH-1:0] floating2_in,
   input  logic                  opcode_in,
   input  logic [TAG_WIDTH-1:0]  tag_in,
   output logic                  out_valid_out,
   input  logic                  out_ready_in,
   output logic [DATA_WIDTH-1:0] result_out,
   output logic [TAG_WIDTH-1:0]  tag_out,
   output logic [3:0]            flags_out
);
   localparam int E  = EXPO_WIDTH;
   localparam int M  = MENT_WIDTH;
   localparam int EW = E + 1;
   localparam int FW = M + 4;
   localparam int SW = $clog2(FW + 1) + 1;
   localparam logic [E-1:0] EXP_ONES = '1;
   localparam logic [E-1:0] EXP_ONE  = {{(E-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic nan;
      logic inf;
      logic inf_sign;
      logic invalid;
      logic zsign;
   } spec_t;

   logic                  advance;
   logic                  s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
   logic [TAG_WIDTH-1:0]  s1_tag_q, s2_tag_q, s3_tag_q, tag_q;
   logic                  s1_sign_q, s2_sign_q, s3_sign_q, s1_sub_q;
   logic [E-1:0]          s1_exp_q, s2_exp_q;
   logic [EW-1:0]         s3_exp_q;
   logic [FW-1:0]         s1_big_q, s1_small_q, s3_mant_q;
   logic [FW:0]           s2_sum_q;
   logic                  s3_zero_q;
   spec_t                 s1_spec_q, s2_spec_q, s3_spec_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [3:0]            flags_q;

   assign advance      = !out_valid_q || out_ready_in;
   assign in_ready_out = advance;

   logic            a_sign, b_sign, a_nan, b_nan, a_inf, b_inf;
   logic            swap, big_sign, small_sign;
   logic [E-1:0]    a_exp, b_exp, a_eexp, b_eexp, big_exp, diff;
   logic [M-1:0]    a_frac, b_frac;
   logic [M:0]      a_sig, b_sig, big_sig, small_sig;
   logic [SW-1:0]   align_sh;
   logic [2*FW-1:0] align_w;
   logic [FW-1:0]   small_al;
   spec_t           spec_d;

   assign a_sign = floating1_in[DATA_WIDTH-1];
   assign b_sign = floating2_in[DATA_WIDTH-1] ^ opcode_in;
   assign a_exp  = floating1_in[M +: E];
   assign b_exp  = floating2_in[M +: E];
   assign a_frac = floating1_in[M-1:0];
   assign b_frac = floating2_in[M-1:0];

   always_comb begin
      a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
      b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
      a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
      b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
      a_eexp = (a_exp == '0) ? EXP_ONE : a_exp;
      b_eexp = (b_exp == '0) ? EXP_ONE : b_exp;
`ifdef FP_ADDSUB_SUBNORMAL_EN
      a_sig = {a_exp != '0, a_frac};
      b_sig = {b_exp != '0, b_frac};
`else
      a_sig = (a_exp != '0) ? {1'b1, a_frac} : '0;
      b_sig = (b_exp != '0) ? {1'b1, b_frac} : '0;
`endif
      swap       = {b_eexp, b_sig} > {a_eexp, a_sig};
      big_sign   = swap ? b_sign : a_sign;
      small_sign = swap ? a_sign : b_sign;
      big_exp    = swap ? b_eexp : a_eexp;
      big_sig    = swap ? b_sig : a_sig;
      small_sig  = swap ? a_sig : b_sig;
      diff       = big_exp - (swap ? a_eexp : b_eexp);
      // Beyond FW every significand bit lands in sticky, so clamp the shifter there.
      align_sh = (int'(diff) > FW) ? SW'(FW) : SW'(diff);
      align_w  = {small_sig, 3'b000, {FW{1'b0}}} >> align_sh;
      small_al = {align_w[2*FW-1:FW+1], align_w[FW] | (|align_w[FW-1:0])};
      spec_d.nan      = a_nan | b_nan | (a_inf & b_inf & (a_sign != b_sign));
      spec_d.inf      = a_inf | b_inf;
      spec_d.inf_sign = a_inf ? a_sign : b_sign;
      spec_d.invalid  = (a_nan & !a_frac[M-1]) | (b_nan & !b_frac[M-1]) |
                        (a_inf & b_inf & (a_sign != b_sign));
      spec_d.zsign    = a_sign & b_sign;
   end

   logic [FW:0] sum2_d;
   assign sum2_d = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                            : ({1'b0, s1_big_q} + {1'b0, s1_small_q});

   logic [SW-1:0] lzc;
   logic [EW-1:0] exp3_w, lim3, exp3_d;
   logic [FW-1:0] mant3_d;
   int            norm_sh;

   always_comb begin
      lzc = SW'(FW);
      for (int i = 0; i < FW; i++) begin
         if (s2_sum_q[i]) lzc = SW'(FW - 1 - i);
      end
      exp3_w = {1'b0, s2_exp_q};
      lim3   = exp3_w - EW'(1);
      // Never normalise below exponent 1: what remains is a subnormal.
      norm_sh = (int'(lzc) > int'(lim3)) ? int'(lim3) : int'(lzc);
      if (s2_sum_q[FW]) begin
         mant3_d = {s2_sum_q[FW:2], s2_sum_q[1] | s2_sum_q[0]};
         exp3_d  = exp3_w + EW'(1);
      end else begin
         mant3_d = s2_sum_q[FW-1:0] << norm_sh;
         exp3_d  = exp3_w - EW'(norm_sh);
      end
   end

   logic [M+1:0]          rnd;
   logic [M:0]            sig4;
   logic [EW-1:0]         exp4;
   logic [E-1:0]          exp_field;
   logic                  inexact4, round_up4;
   logic [DATA_WIDTH-1:0] res_d;
   logic [3:0]            flags_d;

   always_comb begin
      inexact4  = |s3_mant_q[2:0];
      round_up4 = s3_mant_q[2] & (s3_mant_q[3] | s3_mant_q[1] | s3_mant_q[0]);
      rnd       = {1'b0, s3_mant_q[FW-1:3]} + {{(M+1){1'b0}}, round_up4};
      if (rnd[M+1]) begin
         sig4 = rnd[M+1:1];
         exp4 = s3_exp_q + EW'(1);
      end else begin
         sig4 = rnd[M:0];
         exp4 = s3_exp_q;
      end
      exp_field = sig4[M] ? exp4[E-1:0] : '0;
      res_d     = {s3_sign_q, exp_field, sig4[M-1:0]};
      flags_d   = {2'b00, !sig4[M] & inexact4, inexact4};
      if (exp4 >= {1'b0, EXP_ONES}) begin
         res_d   = {s3_sign_q, EXP_ONES, {M{1'b0}}};
         flags_d = 4'b0101;
      end
`ifndef FP_ADDSUB_SUBNORMAL_EN
      else if (!sig4[M]) begin
         res_d   = {s3_sign_q, {(E+M){1'b0}}};
         flags_d = 4'b0011;
      end
`endif
      if (s3_zero_q) begin
         res_d   = {s3_spec_q.zsign, {(E+M){1'b0}}};
         flags_d = 4'b0000;
      end
      if (s3_spec_q.inf) begin
         res_d   = {s3_spec_q.inf_sign, EXP_ONES, {M{1'b0}}};
         flags_d = 4'b0000;
      end
      if (s3_spec_q.nan) begin
         res_d   = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
         flags_d = {s3_spec_q.invalid, 3'b000};
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s3_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         s1_tag_q    <= '0;
         s2_tag_q    <= '0;
         s3_tag_q    <= '0;
         tag_q       <= '0;
         s1_sign_q   <= 1'b0;
         s2_sign_q   <= 1'b0;
         s3_sign_q   <= 1'b0;
         s1_sub_q    <= 1'b0;
         s1_exp_q    <= '0;
         s2_exp_q    <= '0;
         s3_exp_q    <= '0;
         s1_big_q    <= '0;
         s1_small_q  <= '0;
         s2_sum_q    <= '0;
         s3_mant_q   <= '0;
         s3_zero_q   <= 1'b0;
         s1_spec_q   <= '0;
         s2_spec_q   <= '0;
         s3_spec_q   <= '0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (advance) begin
         s1_valid_q  <= in_valid_in;
         s1_tag_q    <= tag_in;
         s1_sign_q   <= big_sign;
         s1_sub_q    <= big_sign ^ small_sign;
         s1_exp_q    <= big_exp;
         s1_big_q    <= {big_sig, 3'b000};
         s1_small_q  <= small_al;
         s1_spec_q   <= spec_d;
         s2_valid_q  <= s1_valid_q;
         s2_tag_q    <= s1_tag_q;
         s2_sign_q   <= s1_sign_q;
         s2_exp_q    <= s1_exp_q;
         s2_sum_q    <= sum2_d;
         s2_spec_q   <= s1_spec_q;
         s3_valid_q  <= s2_valid_q;
         s3_tag_q    <= s2_tag_q;
         s3_sign_q   <= s2_sign_q;
         s3_exp_q    <= exp3_d;
         s3_mant_q   <= mant3_d;
         s3_zero_q   <= (s2_sum_q == '0);
         s3_spec_q   <= s2_spec_q;
         out_valid_q <= s3_valid_q;
         tag_q       <= s3_tag_q;
         result_q    <= res_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid_out = out_valid_q;
   assign result_out    = result_q;
   assign tag_out       = tag_q;
   assign flags_out     = flags_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - directed vector bench for fp_addsub_pipe (single precision)
// Expected values for FP_ADDSUB_SUBNORMAL_EN-dependent vectors follow the macro.
module tb_fp_addsub_pipe;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, op, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [3:0]  tag_i, tag_o, flags;
   int          checks = 0;
   int          errors = 0;

`ifdef FP_ADDSUB_SUBNORMAL_EN
   localparam bit SUBN = 1'b1;
`else
   localparam bit SUBN = 1'b0;
`endif

   always #5 clk = ~clk;

   fp_addsub_pipe dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .in_valid_in  (in_valid),
      .in_ready_out (in_ready),
      .floating1_in (a),
      .floating2_in (b),
      .opcode_in    (op),
      .tag_in       (tag_i),
      .out_valid_out(out_valid),
      .out_ready_in (out_ready),
      .result_out   (result),
      .tag_out      (tag_o),
      .flags_out    (flags)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [3:0]  tag;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] bp_b(input int k);
      return 32'(127 - k) << 23;
   endfunction

   function automatic logic [31:0] bp_res(input int k);
      return 32'h3F800000 | (32'h1 << (23 - k));
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      a        = v.a;
      b        = v.b;
      op       = v.op;
      tag_i    = v.tag;
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_result", idx), result, v.res);
      chk($sformatf("vec%0d_tag", idx), {28'd0, tag_o}, {28'd0, v.tag});
      chk($sformatf("vec%0d_flags", idx), {28'd0, flags}, {28'd0, v.flg});
   endtask

   initial begin
      int sent, got, cyc, extra, stale;
      bit acc, have_hold;
      logic [31:0] hold_res;
      logic [3:0]  hold_tag, hold_flg;

      vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 4'd5,  32'h40400000, 4'h0};
      vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 4'd1,  32'h00000000, 4'h0};
      vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 4'd2,  32'h3F800000, 4'h1};
      vecs[3]  = '{32'h3F800000, 32'h34000000, 1'b0, 4'd3,  32'h3F800001, 4'h0};
      vecs[4]  = '{32'h7F800000, 32'hFF800000, 1'b0, 4'd4,  32'h7FC00000, 4'h8};
      vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd6,  32'h7F800000, 4'h5};
      vecs[6]  = '{32'h00000001, 32'h00000001, 1'b0, 4'd7,  SUBN ? 32'h00000002 : 32'h0, 4'h0};
      vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 4'd8,  32'h7FC00000, 4'h0};
      vecs[8]  = '{32'h7F800001, 32'h3F800000, 1'b0, 4'd9,  32'h7FC00000, 4'h8};
      vecs[9]  = '{32'h3F800000, 32'h7F800000, 1'b1, 4'd10, 32'hFF800000, 4'h0};
      vecs[10] = '{32'h80000000, 32'h80000000, 1'b0, 4'd11, 32'h80000000, 4'h0};
      vecs[11] = '{32'h00000000, 32'h00000000, 1'b1, 4'd12, 32'h00000000, 4'h0};
      vecs[12] = '{32'h3F800000, 32'h3F000000, 1'b1, 4'd13, 32'h3F000000, 4'h0};
      vecs[13] = '{32'h3F800001, 32'h33800000, 1'b0, 4'd14, 32'h3F800002, 4'h1};
      vecs[14] = '{32'h3F800000, 32'h33C00000, 1'b0, 4'd15, 32'h3F800001, 4'h1};
      vecs[15] = '{32'hBF800000, 32'hBF800000, 1'b0, 4'd0,  32'hC0000000, 4'h0};
      vecs[16] = '{32'h00800001, 32'h00800000, 1'b1, 4'd1,  SUBN ? 32'h00000001 : 32'h0,
                   SUBN ? 4'h0 : 4'h3};
      vecs[17] = '{32'h7F800000, 32'h7F800000, 1'b1, 4'd2,  32'h7FC00000, 4'h8};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0;
      a = '0; b = '0; tag_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_tag", {28'd0, tag_o}, 32'd0);
      chk("reset_flags", {28'd0, flags}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

      // Ten back-to-back ops with a six-cycle output stall while the pipe is full.
      @(negedge clk);
      sent = 0; got = 0; cyc = 0; have_hold = 1'b0;
      hold_res = '0; hold_tag = '0; hold_flg = '0;
      op = 1'b0;
      while (got < 10 && cyc < 200) begin
         out_ready = !(cyc >= 5 && cyc < 11);
         in_valid  = (sent < 10);
         a         = 32'h3F800000;
         b         = bp_b(sent + 1);
         tag_i     = 4'(sent);
         #1;
         acc = in_valid && in_ready;
         if (!out_ready && out_valid) begin
            chk("bp_in_ready_stall", {31'd0, in_ready}, 32'd0);
            if (!have_hold) begin
               hold_res  = result;
               hold_tag  = tag_o;
               hold_flg  = flags;
               have_hold = 1'b1;
            end else begin
               chk("bp_hold_result", result, hold_res);
               chk("bp_hold_tag", {28'd0, tag_o}, {28'd0, hold_tag});
               chk("bp_hold_flags", {28'd0, flags}, {28'd0, hold_flg});
            end
         end
         if (out_valid && out_ready) begin
            chk($sformatf("bp%0d_result", got), result, bp_res(got + 1));
            chk($sformatf("bp%0d_tag", got), {28'd0, tag_o}, 32'(got));
            chk($sformatf("bp%0d_flags", got), {28'd0, flags}, 32'd0);
            got++;
         end
         @(negedge clk);
         if (acc) sent++;
         cyc++;
      end
      chk("bp_count", 32'(got), 32'd10);
      chk("bp_stall_seen", {31'd0, have_hold}, 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (out_valid) extra++;
      end
      chk("bp_no_duplicate", 32'(extra), 32'd0);

      // Reset with three ops in flight: none of them may surface.
      @(negedge clk);
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000; op = 1'b0; tag_i = 4'd9;
      repeat (3) @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (out_valid) stale++;
      end
      chk("midrst_stale", 32'(stale), 32'd0);
      run_vec(100, vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
